// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO pop side and stream side of fifo_reader.
// master = reader (i_empty/i_fifo_data/i_ready in; o_read/o_valid/o_data out).
interface fifo_reader_if #(
  parameter int len_data = 32
) ();
  logic                i_empty;
  logic [len_data-1:0] i_fifo_data;
  logic                o_read;
  logic                o_valid;
  logic                i_ready;
  logic [len_data-1:0] o_data;

  modport master (
    input  i_empty,
    input  i_fifo_data,
    input  i_ready,
    output o_read,
    output o_valid,
    output o_data
  );

  modport slave (
    output i_empty,
    output i_fifo_data,
    output i_ready,
    input  o_read,
    input  o_valid,
    input  o_data
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: pops a burst of words from a show-ahead FIFO onto a
// valid/ready stream, one word per cycle sustained.
// Ports: clk, rst_n (async, active-low); i_start/i_burst_len burst request;
// bus (fifo_reader_if.master) FIFO pop + stream; o_busy, o_done, o_err
// status pulses; dbg_remaining words still to pop.
// Optional stall abort enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_reader #(
  parameter int len_data    = 32,
  parameter int timeout_cyc = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_burst_len,
  fifo_reader_if.master bus,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [7:0]    dbg_remaining
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [7:0]          rem;
  logic [7:0]          rem_n;
  logic                done_n;
  logic                err_n;
  logic                rd;
  logic                acc;
  logic                valid_q;
  logic [len_data-1:0] data_q;

  assign acc = valid_q && bus.i_ready;

  // pop only when the output register is free or drains this cycle
  assign rd = (state == BURST) && !bus.i_empty &&
              (rem != 8'd0) && (!valid_q || bus.i_ready);

  assign bus.o_read    = rd;
  assign bus.o_valid   = valid_q;
  assign bus.o_data    = data_q;
  assign o_busy        = (state != IDLE);
  assign dbg_remaining = rem;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int cw = (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
  localparam logic [cw-1:0] cnt_max = cw'(timeout_cyc - 1);

  logic [cw-1:0] cnt;
  logic [cw-1:0] cnt_n;
  logic          stall;

  assign stall = (state == BURST) && bus.i_empty && (rem != 8'd0);
`else
  logic unused_tmo;
  assign unused_tmo = timeout_cyc[0];
`endif

  always_comb begin
    state_n = state;
    rem_n   = rem;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (i_burst_len != 8'd0) begin
            rem_n   = i_burst_len;
            state_n = BURST;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      BURST: begin
        if (rd) begin
          rem_n = rem - 8'd1;
          if (rem == 8'd1) state_n = FLUSH;
        end
`ifdef FIFO_RD_TIMEOUT_EN
        if (rd) begin
          cnt_n = '0;
        end else if (stall) begin
          if (cnt == cnt_max) begin
            // abort: drop the rest, let FLUSH deliver any held word
            cnt_n   = '0;
            err_n   = 1'b1;
            rem_n   = 8'd0;
            state_n = FLUSH;
          end else begin
            cnt_n = cnt + cw'(1);
          end
        end
`endif
      end
      FLUSH: begin
        if (!valid_q || acc) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      o_done  <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      o_done <= done_n;
      if (rd) begin
        data_q  <= bus.i_fifo_data;
        valid_q <= 1'b1;
      end else if (acc) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      o_err <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      o_err <= err_n;
    end
  end
`else
  assign o_err = 1'b0;
  logic unused_err;
  assign unused_err = err_n;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed + random bursts against a queue-based model
// of the FIFO, the stream and the burst bookkeeping.
module tb_fifo_reader;
  localparam int LD  = 32;
  localparam int TMO = 8;
`ifdef FIFO_RD_TIMEOUT_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [7:0]    i_burst_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    dbg;

  fifo_reader_if #(.len_data(LD)) bus ();

  fifo_reader #(
    .len_data(LD),
    .timeout_cyc(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_burst_len(i_burst_len),
    .bus(bus),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .dbg_remaining(dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [LD-1:0] q[$];
  logic [LD-1:0] exp_q[$];
  bit m_busy, done_due, err_due, pop_pend;
  int blen, pops, stall, cyc_n;
  int rd_cnt, first_rd, last_rd, last_acc, done_cyc;
  int delivered, err_seen, done_seen;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pins();
    bus.i_empty = (q.size() == 0);
    if (q.size() != 0) bus.i_fifo_data = q[0];
    else bus.i_fifo_data = '0;
  endtask

  task automatic push(input logic [LD-1:0] w);
    q.push_back(w);
    pins();
  endtask

  task automatic model_reset();
    m_busy = 0;
    done_due = 0;
    err_due = 0;
    pop_pend = 0;
    blen = 0;
    pops = 0;
    stall = 0;
    exp_q.delete();
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    first_rd = 0;
    last_rd = 0;
    last_acc = 0;
    done_cyc = 0;
    delivered = 0;
    err_seen = 0;
    done_seen = 0;
  endtask

  task automatic zeros();
    chk("rst_o_read", 64'(bus.o_read), 64'(0));
    chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_o_data", 64'(bus.o_data), 64'(0));
    chk("rst_o_busy", 64'(busy), 64'(0));
    chk("rst_o_done", 64'(done), 64'(0));
    chk("rst_o_err", 64'(err), 64'(0));
    chk("rst_remaining", 64'(dbg), 64'(0));
  endtask

  task automatic cyc();
    bit was_busy;
    bit rd_exp;
    @(negedge clk);
    cyc_n++;
    if (!rst_n) begin
      zeros();
    end else begin
      was_busy = m_busy;
      rd_exp = m_busy && (pops < blen) && (q.size() != 0) &&
               ((exp_q.size() == 0) || bus.i_ready);
      chk("o_read", 64'(bus.o_read), 64'(rd_exp));
      chk("o_valid", 64'(bus.o_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("o_data", 64'(bus.o_data), 64'(exp_q[0]));
      chk("o_busy", 64'(busy), 64'(m_busy));
      chk("o_done", 64'(done), 64'(done_due));
      chk("o_err", 64'(err), 64'(err_due));
      chk("remaining", 64'(dbg), 64'(m_busy ? blen - pops : 0));
      if (done) begin
        done_seen++;
        done_cyc = cyc_n;
      end
      if (err) err_seen++;
      done_due = 0;
      err_due = 0;
      if (bus.o_valid && bus.i_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
        last_acc = cyc_n;
      end
      if (was_busy && pops == blen && exp_q.size() == 0) begin
        done_due = 1;
        m_busy = 0;
      end
      if (!was_busy && i_start) begin
        if (i_burst_len == 8'd0) begin
          done_due = 1;
        end else begin
          m_busy = 1;
          blen = int'(i_burst_len);
          pops = 0;
          stall = 0;
        end
      end
      if (rd_exp) begin
        exp_q.push_back(q[0]);
        pops++;
        stall = 0;
      end
`ifdef FIFO_RD_TIMEOUT_EN
      else if (was_busy && pops < blen && q.size() == 0) begin
        stall++;
        if (stall == TMO) begin
          err_due = 1;
          blen = pops;
          stall = 0;
        end
      end
`endif
      if (bus.o_read) begin
        rd_cnt++;
        if (rd_cnt == 1) first_rd = cyc_n;
        last_rd = cyc_n;
      end
      pop_pend = bus.o_read && (q.size() != 0);
    end
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(q.pop_front());
      pins();
    end
    pop_pend = 0;
  endtask

  task automatic start(input int len);
    i_start = 1'b1;
    i_burst_len = 8'(len);
    cyc();
    i_start = 1'b0;
    i_burst_len = 8'd0;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((m_busy || done_due || err_due) && n < budget) begin
      cyc();
      n++;
    end
    chk("cycle_budget", 64'(m_busy || done_due || err_due), 64'(0));
  endtask

  initial begin
    int n;
    int len;
    rst_n = 1'b1;
    i_start = 1'b0;
    i_burst_len = 8'd0;
    bus.i_ready = 1'b0;
    cyc_n = 0;
    q.delete();
    pins();
    model_reset();
    clear_stats();
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // four buffered words, sink always ready
    for (int i = 0; i < 4; i++) push(LD'(32'hA0 + i));
    bus.i_ready = 1'b1;
    clear_stats();
    start(4);
    run_idle(50);
    chk("a_reads", 64'(rd_cnt), 64'(4));
    chk("a_consecutive", 64'(last_rd - first_rd), 64'(3));
    chk("a_done_latency", 64'(done_cyc - last_acc), 64'(1));
    chk("a_delivered", 64'(delivered), 64'(4));

    // sink stalls five cycles after the first word
    for (int i = 0; i < 3; i++) push(LD'(32'hB0 + i));
    clear_stats();
    start(3);
    cyc();
    bus.i_ready = 1'b0;
    repeat (5) cyc();
    bus.i_ready = 1'b1;
    run_idle(50);
    chk("b_reads", 64'(rd_cnt), 64'(3));
    chk("b_delivered", 64'(delivered), 64'(3));

    // empty FIFO at start, words arrive later; stray start ignored
    clear_stats();
    start(2);
    for (int i = 0; i < STALL; i++) begin
      if (i == 3) begin
        i_start = 1'b1;
        i_burst_len = 8'd5;
      end
      cyc();
      i_start = 1'b0;
      i_burst_len = 8'd0;
    end
    push(LD'(32'hC0));
    push(LD'(32'hC1));
    run_idle(50);
    chk("c_reads", 64'(rd_cnt), 64'(2));
    chk("c_delivered", 64'(delivered), 64'(2));

    // zero-length burst
    clear_stats();
    start(0);
    run_idle(10);
    chk("d_reads", 64'(rd_cnt), 64'(0));
    chk("d_done", 64'(done_seen), 64'(1));

    // reset in the middle of a burst
    for (int i = 0; i < 6; i++) push(LD'(32'hD0 + i));
    clear_stats();
    start(6);
    n = 0;
    while (pops < 2 && n < 20) begin
      cyc();
      n++;
    end
    chk("e_two_pops", 64'(pops), 64'(2));
    rst_n = 1'b0;
    #1;
    zeros();
    model_reset();
    clear_stats();
    repeat (2) cyc();
    rst_n = 1'b1;
    q.delete();
    pins();
    repeat (3) cyc();
    chk("e_no_done", 64'(done_seen), 64'(0));
    push(LD'(32'hE0));
    start(1);
    run_idle(20);
    chk("e_after_delivered", 64'(delivered), 64'(1));
    chk("e_after_done", 64'(done_seen), 64'(1));

`ifdef FIFO_RD_TIMEOUT_EN
    // only one of three words ever arrives
    push(LD'(32'hF0));
    clear_stats();
    start(3);
    run_idle(50);
    chk("f_delivered", 64'(delivered), 64'(1));
    chk("f_err", 64'(err_seen), 64'(1));
    chk("f_done", 64'(done_seen), 64'(1));
    chk("f_busy", 64'(busy), 64'(0));
`endif

    // longest burst
    for (int i = 0; i < 255; i++) push(LD'($urandom));
    clear_stats();
    start(255);
    run_idle(400);
    chk("g_reads", 64'(rd_cnt), 64'(255));
    chk("g_delivered", 64'(delivered), 64'(255));
    chk("g_fifo_left", 64'(q.size()), 64'(0));

    // random bursts, random arrivals, random back-pressure
    for (int b = 0; b < 12; b++) begin
      len = int'($urandom_range(0, 12));
      bus.i_ready = ($urandom_range(0, 3) != 0);
      start(len);
      n = 0;
      while ((m_busy || done_due || err_due) && n < 600) begin
        bus.i_ready = ($urandom_range(0, 3) != 0);
        if (q.size() < 8 && $urandom_range(0, 1) == 1)
          push(LD'($urandom));
        cyc();
        n++;
      end
      chk("rand_budget", 64'(m_busy || done_due || err_due), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
